// File: rtl/regfile_sb_pkg.sv
// Shared constants and FSM state encoding for the scoreboarded register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_sb_pkg;

  // Default geometry: 32 entries of 64 bits.
  localparam int DW_DEFAULT = 64;
  localparam int AW_DEFAULT = 5;

  // CLEAR walks the array writing zeros; READY is terminal until reset.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle for the register file: one write port, busy-set port, two read ports.
// Latency: read data and busy flags are combinational from the addresses.
// Backpressure: none; Rdy low means writes and busy-sets are dropped.
//
// Ports (slave = register file side):
//   W_En/W_Addr/WR       write request
//   Busy_Set/Busy_Addr   mark an entry as having a pending producer
//   R_Addr/S_Addr        read addresses
//   R/S, R_Busy/S_Busy   read data and pending flags
//   Rdy                  clear sequence finished
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
);

  logic          W_En;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] WR;
  logic [AW-1:0] R_Addr;
  logic [AW-1:0] S_Addr;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic          Busy_Set;
  logic [AW-1:0] Busy_Addr;
  logic          R_Busy;
  logic          S_Busy;
  logic          Rdy;

  // Issue/datapath side.
  modport master (
    output W_En, W_Addr, WR, R_Addr, S_Addr, Busy_Set, Busy_Addr,
    input  R, S, R_Busy, S_Busy, Rdy
  );

  // Register file side.
  modport slave (
    input  W_En, W_Addr, WR, R_Addr, S_Addr, Busy_Set, Busy_Addr,
    output R, S, R_Busy, S_Busy, Rdy
  );

endinterface

// File: rtl/regfile_sb_rdport.sv
// One read port: selects zero-register, write bypass or array data, and qualifies busy.
// Latency: purely combinational.
// Backpressure: none; outputs forced to zero while the array is still clearing.
//
// Ports:
//   ready_i               array cleared, normal operation
//   addr_i                read address
//   wr_vld_i/wr_addr_i    valid (non-suppressed) write this cycle
//   wr_dat_i              write data, forwarded on a bypass hit
//   mem_dat_i/busy_i      array contents and busy bit at addr_i
//   rd_dat_o/busy_o       read data and pending flag
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          ready_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_vld_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic [DW-1:0] mem_dat_i,
  input  logic          busy_i,
  output logic [DW-1:0] rd_dat_o,
  output logic          busy_o
);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (addr_i == '0);
  // wr_vld_i already excludes writes to the zero register, so a bypass hit
  // can never override the zero rule.
  assign byp_hit  = (BYPASS != 0) && wr_vld_i && (wr_addr_i == addr_i);

  always_comb begin
    rd_dat_o = '0;
    busy_o   = 1'b0;
    if (ready_i) begin
      if (zero_hit) begin
        rd_dat_o = '0;
      end else if (byp_hit) begin
        rd_dat_o = wr_dat_i;
      end else begin
        rd_dat_o = mem_dat_i;
      end
      // The forwarded value is the one the consumer was waiting for.
      busy_o = busy_i && !byp_hit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: 1 write port, 2 combinational read ports, busy scoreboard.
// Latency: writes/busy updates land on the next clk edge; reads are combinational.
// Backpressure: none; Rdy rises 2**AW edges after reset, inputs ignored until then.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; restarts the clear sequence
//   bus    regfile_sb_if slave modport (write, busy-set, R/S read ports, Rdy)
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic             clr_we;
  logic             ready;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  logic             wr_vld;
  logic             set_vld;

  assign ready = (state_q == READY);

  // Writes and busy-sets only count once the array is clean, and never
  // touch entry 0 when it is the hardwired zero register.
  assign wr_vld  = ready && bus.W_En
                   && !((ZERO_REG != 0) && (bus.W_Addr == '0));
  assign set_vld = ready && bus.Busy_Set
                   && !((ZERO_REG != 0) && (bus.Busy_Addr == '0));

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      // Leave on the edge that clears the last entry; the pointer stops at
      // DEPTH-1 instead of wrapping back to 0.
      if (clr_ptr_q == {AW{1'b1}}) begin
        state_d = READY;
      end else begin
        clr_ptr_d = clr_ptr_q + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset of its own, zeroed by the clear walk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_vld) begin
      mem[bus.W_Addr] <= bus.WR;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr_vld) begin
      busy_d[bus.W_Addr] = 1'b0;
    end
    // Applied after the write clear: a new producer on the same entry wins.
    if (set_vld) begin
      busy_d[bus.Busy_Addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  regfile_sb_rdport #(
    .DW       (DW),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd_r (
    .ready_i   (ready),
    .addr_i    (bus.R_Addr),
    .wr_vld_i  (wr_vld),
    .wr_addr_i (bus.W_Addr),
    .wr_dat_i  (bus.WR),
    .mem_dat_i (mem[bus.R_Addr]),
    .busy_i    (busy_q[bus.R_Addr]),
    .rd_dat_o  (bus.R),
    .busy_o    (bus.R_Busy)
  );

  regfile_sb_rdport #(
    .DW       (DW),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rd_s (
    .ready_i   (ready),
    .addr_i    (bus.S_Addr),
    .wr_vld_i  (wr_vld),
    .wr_addr_i (bus.W_Addr),
    .wr_dat_i  (bus.WR),
    .mem_dat_i (mem[bus.S_Addr]),
    .busy_i    (busy_q[bus.S_Addr]),
    .rd_dat_o  (bus.S),
    .busy_o    (bus.S_Busy)
  );

  assign bus.Rdy = ready;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read register file with one write port and two combinational read ports (R and S). It replaces the fixed 32x64 register file in the datapath. New behaviour over the fixed version:
- hardware-cleared contents after reset, via a sequential clear state machine
- optional write-to-read bypass
- optional hardwired zero register
- per-register busy scoreboard, so the issue logic can detect pending writes.

Parameters:
DW, 64, data width in bits
AW, 5, address width; DEPTH = 2**AW entries (derived localparam, not overridable)
ZERO_REG, 1, 1: entry 0 always reads 0, and writes/busy-sets to it are ignored
BYPASS, 1, 1: a same-cycle write is forwarded to a matching read port

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
W_En  in  1  write enable
W_Addr  in  AW  write address
WR  in  DW  write data
R_Addr  in  AW  R port read address
S_Addr  in  AW  S port read address
R  out  DW  R port read data (combinational)
S  out  DW  S port read data (combinational)
Busy_Set  in  1  mark register Busy_Addr pending
Busy_Addr  in  AW  register to mark pending
R_Busy  out  1  R operand pending
S_Busy  out  1  S operand pending
Rdy  out  1  clear sequence done; block accepts writes

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = CLEAR, clr_ptr = 0
  - all busy bits = 0, Rdy = 0
  - R = S = 0, R_Busy = S_Busy = 0
- The storage array has no reset of its own; it is cleared only by the FSM.
- FSM, two states:
  - CLEAR: each clk writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr == DEPTH-1, go to READY on the same edge.
  - READY: terminal state. Only reset leaves it.
- Clear timing: DEPTH rising edges after reset deasserts; Rdy = 1 from the DEPTH-th edge onward. Rdy is registered (state == READY).
- During CLEAR:
  - W_En and Busy_Set are ignored.
  - R = S = 0 and R_Busy = S_Busy = 0 regardless of address.
- Reset mid-CLEAR or in READY: returns to CLEAR and restarts the clear at entry 0.
- Write (READY only): on a clk edge with W_En = 1, mem[W_Addr] <= WR. Suppressed when ZERO_REG = 1 and W_Addr == 0. A suppressed write is called "invalid" below.
- Read (READY only), evaluated per port, highest priority first:
  1. ZERO_REG = 1 and addr == 0 → 0.
  2. BYPASS = 1, W_En = 1 and W_Addr == addr → WR.
  3. Otherwise → mem[addr].
  Both ports may read the same address; R and S are independent.
- Scoreboard: one busy bit per entry, updated on clk edges in READY.
  - Busy_Set sets busy[Busy_Addr].
  - A valid write clears busy[W_Addr].
  - Set and write to the same address in the same cycle: busy stays 1 (the new producer wins).
  - Busy_Set to entry 0 with ZERO_REG = 1 is ignored.
- Busy outputs:
  - R_Busy = busy[R_Addr], forced 0 when the bypass hit for R is active (BYPASS = 1, valid write to R_Addr this cycle). S_Busy follows the same rule.
  - With BYPASS = 0, R_Busy = busy[R_Addr] even during a write to that address.
- Widths: no arithmetic on data. clr_ptr is AW bits and must not wrap past DEPTH-1.

Decomposition:
- Shared package holds:
  - the default constants (DW_DEFAULT = 64, AW_DEFAULT = 5)
  - the state encoding: CLEAR = 1'b0, READY = 1'b1
- One natural sub-module, regfile_sb_rdport: the per-port read mux covering zero, bypass, array data and the busy qualification. It is instantiated twice, for R and S.

Test Plan:
- Clear sequence: assert reset, then deassert. Rdy = 0 for 31 edges and 1 on the 32nd edge. Afterwards, reads of all 32 addresses return 0 and R_Busy = 0.
- Write/read, both ports: write 64'hDEADBEEF_CAFEF00D to entry 7, then R_Addr = 7 and S_Addr = 7 next cycle → both R and S equal that value. A write of 64'h1 to entry 0 → R_Addr = 0 reads 0.
- Bypass: in the same cycle, W_En = 1, W_Addr = 12, WR = 64'h55, R_Addr = 12 → R = 64'h55 combinationally before the edge. Rerun with BYPASS = 0 → R shows the old value (0).
- Scoreboard: Busy_Set on entry 3 → next cycle R_Addr = 3 gives R_Busy = 1. Write 64'hA to entry 3 → R_Busy = 0 during the write cycle (bypass) and 0 afterwards. Busy_Set and a write to entry 3 in the same cycle → R_Busy = 1 after the edge.
- Reset mid-operation: write entries 1 to 5, then pulse reset asynchronously between edges. Rdy drops immediately, the busy bits clear, and after 32 edges entries 1 to 5 read 0.
- Writes ignored in CLEAR: W_En = 1 to entry 9 with 64'hFF at edge 10 of the clear → after Rdy, entry 9 reads 0.
